// File: rtl/pipeio.sv
// pipeio: memory-mapped I/O port for the data side of the CPU memory stage.
//
// Synchronises and debounces two 5-bit switch inputs, holds a CPU-writable
// 32-bit total register with a read-to-clear change-status register, and
// drives six seven-segment digits plus a 10-bit bar from registered state.
//
// Optional feature macro: PIPEIO_DEBOUNCE_EN
//   defined   : per-input debounce counter, DEBOUNCE_CYCLES honoured
//   undefined : accepted value follows the synchronised input every cycle
//
// Parameters
//   IO_BASE          word-aligned base of the 16-byte I/O window
//   DEBOUNCE_CYCLES  stable synchronised samples needed to accept a change
//
// Ports
//   clock, resetn     clock and asynchronous active-low reset
//   io_we, io_rd      write / read strobes of the current access
//   io_addr, io_wdata byte address and store data
//   io_rdata, io_hit  combinational read data and window decode
//   plus1, plus2      asynchronous 5-bit switch inputs
//   *_high, *_low     registered active-low seven-segment digits (gfedcba)
//   lcd               registered copy of total[9:0]
//
// Address map (offset = io_addr[3:2])
//   0: debounced plus1 (RO)   1: debounced plus2 (RO)
//   2: total (RW)             3: {chg2, chg1} (read-to-clear)

module pipeio #(
    parameter logic [31:0] IO_BASE         = 32'h0000_0080,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        io_we,
    input  logic        io_rd,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    output logic        io_hit,
    input  logic [4:0]  plus1,
    input  logic [4:0]  plus2,
    output logic [6:0]  plus1_high,
    output logic [6:0]  plus1_low,
    output logic [6:0]  plus2_high,
    output logic [6:0]  plus2_low,
    output logic [6:0]  total_high,
    output logic [6:0]  total_low,
    output logic [9:0]  lcd
);

    localparam int unsigned DW   = 32;
    localparam int unsigned SW   = 5;
    localparam int unsigned NCH  = 2;
    localparam int unsigned SEGW = 7;
    localparam int unsigned LCDW = 10;

    localparam logic [1:0] OFF_DB1   = 2'd0;
    localparam logic [1:0] OFF_DB2   = 2'd1;
    localparam logic [1:0] OFF_TOTAL = 2'd2;
    localparam logic [1:0] OFF_STAT  = 2'd3;

    localparam logic [SEGW-1:0] SEG_ZERO  = 7'b1000000;
    localparam logic [SEGW-1:0] SEG_DASH  = 7'b0111111;
    localparam logic [SEGW-1:0] SEG_BLANK = 7'b1111111;

    // Decimal digit to active-low gfedcba segment pattern.
    function automatic logic [SEGW-1:0] seg7(input logic [3:0] d);
        logic [SEGW-1:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Two-digit display of a 0..31 switch value: {high, low}.
    function automatic logic [2*SEGW-1:0] split_db(input logic [SW-1:0] v);
        logic [SW-1:0] hi;
        logic [SW-1:0] lo;
        hi = v / SW'(10);
        lo = v % SW'(10);
        return {seg7(4'(hi)), seg7(4'(lo))};
    endfunction

    // Two-digit display of total; anything above 99 shows two dashes.
    function automatic logic [2*SEGW-1:0] split_total(input logic [DW-1:0] v);
        logic [6:0]        n;
        logic [6:0]        hi;
        logic [6:0]        lo;
        logic [2*SEGW-1:0] r;
        n  = v[6:0];
        hi = n / 7'd10;
        lo = n % 7'd10;
        if (v > DW'(99)) begin
            r = {SEG_DASH, SEG_DASH};
        end else begin
            r = {seg7(4'(hi)), seg7(4'(lo))};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NCH-1:0][SW-1:0] plus_c;
    logic [NCH-1:0][SW-1:0] s1_q;
    logic [NCH-1:0][SW-1:0] s2_q;
    logic [NCH-1:0][SW-1:0] db_q;
    logic [NCH-1:0][SW-1:0] db_d;
    logic [NCH-1:0]         chg_q;
    logic [NCH-1:0]         chg_d;
    logic [NCH-1:0]         chg_set_c;
    logic [DW-1:0]          total_q;
    logic [DW-1:0]          total_d;

    logic [1:0]             off_c;
    logic                   wr_total_c;
    logic                   stat_clr_c;
    logic [2*SEGW-1:0]      p1_seg_c;
    logic [2*SEGW-1:0]      p2_seg_c;
    logic [2*SEGW-1:0]      tot_seg_c;

    // Byte-lane bits of the address are ignored; the parameter is only
    // consumed by the counter when debounce is built.
    logic                   unused_c;
    assign unused_c = ^{io_addr[1:0], 8'(DEBOUNCE_CYCLES)};

    assign plus_c = {plus2, plus1};

    // Window decode and access qualification.
    assign io_hit     = (io_addr[31:4] == IO_BASE[31:4]);
    assign off_c      = io_addr[3:2];
    assign wr_total_c = io_we & io_hit & (off_c == OFF_TOTAL);
    assign stat_clr_c = io_rd & io_hit & (off_c == OFF_STAT);

    // Read mux straight off registered state; writes in the same cycle are
    // not bypassed.
    always_comb begin
        io_rdata = '0;
        if (io_hit) begin
            case (off_c)
                OFF_DB1:   io_rdata = {27'b0, db_q[0]};
                OFF_DB2:   io_rdata = {27'b0, db_q[1]};
                OFF_TOTAL: io_rdata = total_q;
                OFF_STAT:  io_rdata = {30'b0, chg_q};
                default:   io_rdata = '0;
            endcase
        end
    end

    assign total_d = wr_total_c ? io_wdata : total_q;

`ifdef PIPEIO_DEBOUNCE_EN
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NCH-1:0][CW-1:0] cnt_q;
    logic [NCH-1:0][CW-1:0] cnt_d;

    // Accept a new value only after it has been seen DEBOUNCE_CYCLES times
    // in a row; any return to the accepted value restarts the count.
    always_comb begin
        db_d      = db_q;
        cnt_d     = '0;
        chg_set_c = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                db_d[i]      = s2_q[i];
                cnt_d[i]     = '0;
                chg_set_c[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // No filtering: the accepted value tracks the synchroniser output.
    always_comb begin
        db_d      = db_q;
        chg_set_c = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            db_d[i]      = s2_q[i];
            chg_set_c[i] = (s2_q[i] != db_q[i]);
        end
    end
`endif

    // A change event in the same cycle as a status read keeps its bit set.
    assign chg_d = chg_set_c | (chg_q & ~{NCH{stat_clr_c}});

    assign p1_seg_c  = split_db(db_q[0]);
    assign p2_seg_c  = split_db(db_q[1]);
    assign tot_seg_c = split_total(total_q);

    // Synchronisers, accepted values, status, total and display registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_q       <= '0;
            s2_q       <= '0;
            db_q       <= '0;
            chg_q      <= '0;
            total_q    <= '0;
            lcd        <= '0;
            plus1_high <= SEG_ZERO;
            plus1_low  <= SEG_ZERO;
            plus2_high <= SEG_ZERO;
            plus2_low  <= SEG_ZERO;
            total_high <= SEG_ZERO;
            total_low  <= SEG_ZERO;
        end else begin
            s1_q       <= plus_c;
            s2_q       <= s1_q;
            db_q       <= db_d;
            chg_q      <= chg_d;
            total_q    <= total_d;
            lcd        <= total_q[LCDW-1:0];
            plus1_high <= p1_seg_c[2*SEGW-1:SEGW];
            plus1_low  <= p1_seg_c[SEGW-1:0];
            plus2_high <= p2_seg_c[2*SEGW-1:SEGW];
            plus2_low  <= p2_seg_c[SEGW-1:0];
            total_high <= tot_seg_c[2*SEGW-1:SEGW];
            total_low  <= tot_seg_c[SEGW-1:0];
        end
    end

endmodule

// File: tb/tb_pipeio.sv
`timescale 1ns/1ps
// Directed, table-driven bench for pipeio.
module tb_pipeio;

    localparam logic [31:0] BASE = 32'h0000_0080;
`ifdef PIPEIO_DEBOUNCE_EN
    localparam int ACC   = 5;
    localparam bit DB_EN = 1'b1;
`else
    localparam int ACC   = 2;
    localparam bit DB_EN = 1'b0;
`endif
    localparam int DASH = 10;

    logic        clock;
    logic        resetn;
    logic        io_we;
    logic        io_rd;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        io_hit;
    logic [4:0]  plus1;
    logic [4:0]  plus2;
    logic [6:0]  plus1_high, plus1_low, plus2_high, plus2_low;
    logic [6:0]  total_high, total_low;
    logic [9:0]  lcd;

    int tests;
    int fails;

    pipeio #(.IO_BASE(BASE), .DEBOUNCE_CYCLES(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .io_we      (io_we),
        .io_rd      (io_rd),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .io_hit     (io_hit),
        .plus1      (plus1),
        .plus2      (plus2),
        .plus1_high (plus1_high),
        .plus1_low  (plus1_low),
        .plus2_high (plus2_high),
        .plus2_low  (plus2_low),
        .total_high (total_high),
        .total_low  (total_low),
        .lcd        (lcd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg(input int d);
        logic [6:0] s;
        case (d)
            0: s = 7'b1000000;  1: s = 7'b1111001;  2: s = 7'b0100100;
            3: s = 7'b0110000;  4: s = 7'b0011001;  5: s = 7'b0010010;
            6: s = 7'b0000010;  7: s = 7'b1111000;  8: s = 7'b0000000;
            9: s = 7'b0010000;  default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    function automatic logic [13:0] pair(input int h, input int l);
        return {seg(h), seg(l)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_rd(input string nm, input logic [1:0] off, input logic [31:0] exp);
        io_rd   = 1'b0;
        io_we   = 1'b0;
        io_addr = BASE + {28'd0, off, 2'b00};
        #1;
        chk(nm, 64'(io_rdata), 64'(exp));
    endtask

    task automatic chk_digits(input string nm, input int a, input int b, input int c,
                              input int d, input int e, input int f);
        chk({nm, "_p1"}, 64'({plus1_high, plus1_low}), 64'(pair(a, b)));
        chk({nm, "_p2"}, 64'({plus2_high, plus2_low}), 64'(pair(c, d)));
        chk({nm, "_tot"}, 64'({total_high, total_low}), 64'(pair(e, f)));
    endtask

    typedef struct {
        logic [31:0] val;
        logic [9:0]  lcd;
        int          hi;
        int          lo;
    } tvec_t;

    tvec_t       tv [9];
    logic [31:0] prev_total;
    logic [9:0]  prev_lcd;

    initial begin
        tv[0] = '{32'd42,         10'd42,  4,    2};
        tv[1] = '{32'd150,        10'd150, DASH, DASH};
        tv[2] = '{32'd0,          10'd0,   0,    0};
        tv[3] = '{32'd99,         10'd99,  9,    9};
        tv[4] = '{32'd100,        10'd100, DASH, DASH};
        tv[5] = '{32'd7,          10'd7,   0,    7};
        tv[6] = '{32'd1024,       10'd0,   DASH, DASH};
        tv[7] = '{32'hFFFF_FFFF,  10'h3FF, DASH, DASH};
        tv[8] = '{32'd42,         10'd42,  4,    2};

        tests    = 0;
        fails    = 0;
        io_we    = 1'b0;
        io_rd    = 1'b0;
        io_addr  = BASE;
        io_wdata = '0;
        plus1    = '0;
        plus2    = '0;
        resetn   = 1'b1;
        #1 resetn = 1'b0;
        #1;

        // Reset state
        chk_rd("rst_off0", 2'd0, 32'd0);
        chk_rd("rst_off1", 2'd1, 32'd0);
        chk_rd("rst_off2", 2'd2, 32'd0);
        chk_rd("rst_off3", 2'd3, 32'd0);
        chk("rst_lcd", 64'(lcd), 64'd0);
        chk_digits("rst_dig", 0, 0, 0, 0, 0, 0);
        tick();
        resetn = 1'b1;

        // Debounce accept: plus1 0 -> 23
        plus1 = 5'd23;
        for (int k = 0; k <= ACC + 1; k++) begin
            tick();
            chk_rd($sformatf("acc_db1_e%0d", k), 2'd0, (k >= ACC) ? 32'd23 : 32'd0);
            chk($sformatf("acc_dig1_e%0d", k), 64'({plus1_high, plus1_low}),
                64'((k >= ACC + 1) ? pair(2, 3) : pair(0, 0)));
        end
        chk_rd("acc_status", 2'd3, 32'd1);

        // Read-to-clear
        io_addr = BASE + 32'd12;
        io_rd   = 1'b1;
        #1;
        chk("clr_read", 64'(io_rdata), 64'd1);
        tick();
        chk_rd("clr_after", 2'd3, 32'd0);

        // Glitch: plus2 = 5 for three cycles
        plus2 = 5'd5;
        tick(); tick(); tick();
        plus2 = 5'd0;
        chk_rd("glitch_mid", 2'd1, DB_EN ? 32'd0 : 32'd5);
        for (int k = 0; k < 8; k++) tick();
        chk_rd("glitch_db2", 2'd1, 32'd0);
        chk_rd("glitch_status", 2'd3, DB_EN ? 32'd0 : 32'd2);
        chk("glitch_dig2", 64'({plus2_high, plus2_low}), 64'(pair(0, 0)));
        io_addr = BASE + 32'd12;
        io_rd   = 1'b1;
        tick();
        chk_rd("glitch_clr", 2'd3, 32'd0);

        // Total write / display table
        prev_total = 32'd0;
        prev_lcd   = 10'd0;
        for (int i = 0; i < 9; i++) begin
            io_rd    = 1'b0;
            io_addr  = BASE + 32'd8;
            io_wdata = tv[i].val;
            io_we    = 1'b1;
            #1;
            chk($sformatf("wr%0d_same_cycle", i), 64'(io_rdata), 64'(prev_total));
            tick();
            io_we = 1'b0;
            #1;
            chk($sformatf("wr%0d_visible", i), 64'(io_rdata), 64'(tv[i].val));
            chk($sformatf("wr%0d_lcd_lag", i), 64'(lcd), 64'(prev_lcd));
            tick();
            chk($sformatf("wr%0d_lcd", i), 64'(lcd), 64'(tv[i].lcd));
            chk($sformatf("wr%0d_dig", i), 64'({total_high, total_low}),
                64'(pair(tv[i].hi, tv[i].lo)));
            prev_total = tv[i].val;
            prev_lcd   = tv[i].lcd;
        end

        // Status clear racing a db1 change
        plus1 = 5'd9;
        for (int k = 0; k < ACC; k++) tick();
        chk_rd("race_pre_db1", 2'd0, 32'd23);
        io_addr = BASE + 32'd12;
        io_rd   = 1'b1;
        #1;
        chk("race_first", 64'(io_rdata), 64'd0);
        tick();
        chk("race_second", 64'(io_rdata), 64'd1);
        tick();
        chk("race_third", 64'(io_rdata), 64'd0);
        io_rd = 1'b0;
        chk_rd("race_db1", 2'd0, 32'd9);

        // Decode
        io_addr  = BASE + 32'd16;
        io_wdata = 32'd77;
        io_we    = 1'b1;
        #1;
        chk("dec_out_hit", 64'(io_hit), 64'd0);
        chk("dec_out_rdata", 64'(io_rdata), 64'd0);
        io_addr = BASE - 32'd4;
        #1;
        chk("dec_below_hit", 64'(io_hit), 64'd0);
        tick();
        io_addr  = BASE;
        io_wdata = 32'd31;
        #1;
        chk("dec_off0_hit", 64'(io_hit), 64'd1);
        tick();
        io_addr  = BASE + 32'd12;
        io_wdata = 32'd3;
        tick();
        io_we = 1'b0;
        chk_rd("dec_db1", 2'd0, 32'd9);
        chk_rd("dec_total", 2'd2, 32'd42);
        chk_rd("dec_status", 2'd3, 32'd0);
        io_addr = BASE + 32'd11;
        #1;
        chk("dec_byte_bits", 64'(io_rdata), 64'd42);
        chk("dec_lcd", 64'(lcd), 64'd42);

        // Asynchronous reset in the middle of a debounce
        plus2 = 5'd17;
        tick(); tick();
        #2 resetn = 1'b0;
        #1;
        chk_rd("arst_off0", 2'd0, 32'd0);
        chk_rd("arst_off1", 2'd1, 32'd0);
        chk_rd("arst_off2", 2'd2, 32'd0);
        chk_rd("arst_off3", 2'd3, 32'd0);
        chk("arst_lcd", 64'(lcd), 64'd0);
        chk_digits("arst_dig", 0, 0, 0, 0, 0, 0);
        tick(); tick();
        resetn = 1'b1;
        for (int k = 0; k <= ACC; k++) begin
            tick();
            chk_rd($sformatf("rel_db2_e%0d", k), 2'd1, (k >= ACC) ? 32'd17 : 32'd0);
            chk_rd($sformatf("rel_db1_e%0d", k), 2'd0, (k >= ACC) ? 32'd9 : 32'd0);
        end
        tick();
        chk_digits("rel_dig", 0, 9, 1, 7, 0, 0);
        chk_rd("rel_status", 2'd3, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeio.md
# pipeio

Memory-mapped I/O port on the data side of the memory stage of the pipelined CPU. It synchronises and debounces the two 5-bit switch inputs `plus1` and `plus2` and exposes them as readable words. It holds a CPU-writable `total` register with a change-status register, and drives the six seven-segment digits and the 10-bit `lcd` bar from registered state. The memory stage forwards word accesses to it and takes `io_rdata` in the same cycle whenever `io_hit` is high.

## Interface
- `IO_BASE`, default 32'h0000_0080: word-aligned base address of the 16-byte I/O window.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples needed to accept a switch change (range 1..255).
- `clock`  in  1  single clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `io_we`  in  1  write strobe for the current access.
- `io_rd`  in  1  read strobe; qualifies read side effects (status clear).
- `io_addr`  in  32  byte address (ALU result).
- `io_wdata`  in  32  write data (store operand).
- `io_rdata`  out  32  read data, combinational from registered state.
- `io_hit`  out  1  combinational: `io_addr[31:4] == IO_BASE[31:4]`.
- `plus1`, `plus2`  in  5 each  asynchronous switch inputs.
- `plus1_high`, `plus1_low`, `plus2_high`, `plus2_low`, `total_high`, `total_low`  out  7 each  registered seven-segment digits, active-low, bit order gfedcba.
- `lcd`  out  10  registered copy of `total[9:0]`.

## Operation
- **Address map** (offset = `io_addr[3:2]`, `io_addr[1:0]` ignored):
  - 0: `{27'b0, db1}`, read-only.
  - 1: `{27'b0, db2}`, read-only.
  - 2: `total`, read/write 32-bit.
  - 3: `{30'b0, chg2, chg1}`, read-to-clear.
- Writes to offsets 0, 1 and 3 are ignored.
- `io_rdata` = 0 when `io_hit` = 0.
- **Write:** a write takes effect when `io_we & io_hit`.
- **Synchroniser:** two flops per input, `s1 <= plus`, `s2 <= s1`.
- **Debounce**, per input, with 8-bit counter `cnt` and accepted value `db`:
  - If `s2 == db`, then `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`, then `db <= s2`, `cnt <= 0`, `chg <= 1`.
  - Else `cnt <= cnt+1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` samples resets `cnt` and never reaches `db`.
- **Status clear:** `io_rd & io_hit & offset==3` clears both `chg` bits at the edge.
  - A set event in the same cycle wins: that bit stays 1.
  - The read returns the pre-edge value.
- **Digit display:**
  - For values 0..99: high = value/10, low = value%10.
  - Encoding: 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000.
  - `plus1`/`plus2` digits come from `db1`/`db2` (0..31).
  - `total` digits: if `total > 99` (unsigned), both digits show dash 7'b0111111.
- **Reset (`resetn` low, asynchronous):**
  - Cleared to 0: `s1`, `s2`, `db`, `cnt`, `chg`, `total`, `lcd`.
  - All six digit outputs go to 7'b1000000.
  - A reset mid-debounce discards the partial count.

## Timing
- `io_rdata` and `io_hit` have zero latency (combinational); the memory stage samples them in the same cycle.
- **Write visibility:**
  - A write at edge N makes `total` visible on `io_rdata` after edge N.
  - `lcd` and the `total` digits update at edge N+1.
- **Same-cycle write and read of offset 2:** no bypass; the read returns the old value.
- **Switch latency:**
  - Input stable before edge 0 gives `s2` valid after edge 1.
  - `db` and `chg` update at edge 1+`DEBOUNCE_CYCLES` (default: edge 5).
  - Digits update one edge later.

## Configuration
- **`PIPEIO_DEBOUNCE_EN` defined:** the debounce counter is built as described; `DEBOUNCE_CYCLES` is honoured.
- **`PIPEIO_DEBOUNCE_EN` undefined:**
  - No counter is built and `DEBOUNCE_CYCLES` is unused.
  - `db <= s2` every cycle; `chg` sets on any `s2 != db`.
  - `db` updates at edge 2 after input change.

## Test plan
- **Reset:** assert `resetn`=0 mid-run. Expect all read offsets 0, `lcd`=0, all digits 7'b1000000, asynchronously without a clock edge.
- **Debounce accept:** `plus1` 0→23 and held (macro on, default). Expect offset 0 reads 23 after edge 5, not after edge 4; `plus1_high`=7'b0100100, `plus1_low`=7'b0110000 after edge 6; offset 3 reads 1.
- **Glitch reject:** `plus2`=5 for 3 cycles then back to 0. Expect offset 1 stays 0 and `chg2` stays 0.
- **Total write/display:**
  - Write 42 to `IO_BASE+8`: expect read 42 the next cycle, `lcd`=42, digits 4/2.
  - Write 150: expect both `total` digits 7'b0111111 and `lcd`=150.
- **Status clear race:** read offset 3 with `io_rd`=1 in the same cycle `db1` changes. Expect the read returns the old status and `chg1` stays 1 afterwards. A second read returns 1, then a third read returns 0.
- **Decode:** write to `IO_BASE+16` or to offset 0 with `io_we`=1. Expect `io_hit`=0 in the first case, and no state change in either case.
